reg_writeback_queue: RTL and testbench
======================================

# reg_writeback_queue

Register-file write-back unit for the MIPS datapath: accepts ALU results (destination register plus 32-bit value) through a valid/ready handshake, buffers them in a small in-order FIFO, and drives the register file's write port (`RegWrite`, `WriteReg`, `WriteData`), one write per cycle. It is the writer counterpart of the register file's read side. It also reports pending-write hazards and forwarding data for the two decode-stage read addresses.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `DATA_W`, 32: result width.
- `ADDR_W`, 5: register address width.

- `CLK`  in  1  clock; all state updates on posedge.
- `RESET`  in  1  asynchronous, active-high; clock `CLK`.
- `in_valid`  in  1  ALU result present.
- `in_ready`  out  1  queue can accept this cycle.
- `in_reg`  in  ADDR_W  destination register.
- `in_data`  in  DATA_W  result value.
- `wr_hold`  in  1  register file busy; no pop this cycle.
- `RegWrite`  out  1  write strobe to register file (registered).
- `WriteReg`  out  ADDR_W  write address (registered).
- `WriteData`  out  DATA_W  write data (registered).
- `ReadReg1`, `ReadReg2`  in  ADDR_W  decode-stage read addresses.
- `hazard1`, `hazard2`  out  1  pending write to ReadRegN.
- `fwd_data1`, `fwd_data2`  out  DATA_W  newest pending value for ReadRegN.
- `count`  out  log2(DEPTH)+1  occupied entries.
- `empty`, `full`  out  1  count==0 / count==DEPTH.

## Operation
- Push: `in_valid && in_ready` at posedge. `in_reg != 0` → entry appended at tail. `in_reg == 0` → handshake completes, entry discarded (register 0 never written).
- `in_ready = !full`, based on the registered count. When full, a same-cycle pop does not raise `in_ready`.
- Pop: at posedge, if `!empty && !wr_hold`, the head entry is removed and loaded into the output register. `RegWrite` goes to 1 and `WriteReg`/`WriteData` take the head's fields. Otherwise `RegWrite` goes to 0, and `WriteReg`/`WriteData` hold their previous values.
- The register file commits at the posedge where `RegWrite` is 1.
- Simultaneous push and pop (not full): both occur and `count` is unchanged. The push-and-pop-while-empty case does not exist, because a pop requires `!empty` before the edge.
- Pointers are ADDR of log2(DEPTH) bits and wrap modulo DEPTH. `count` is tracked separately, or derived from pointers with an extra wrap bit.
- Order: writes leave strictly in acceptance order. Two pending writes to the same register both reach the register file, oldest first.
- Hazard/forward (combinational):
  - Candidates are all valid queue entries plus the output register while `RegWrite` is 1.
  - `hazardN` = any candidate has reg == ReadRegN.
  - `fwd_dataN` = data of the newest matching candidate (most recently accepted). The output register is the oldest candidate.
  - `ReadRegN == 0` or no match → `hazardN` = 0 and `fwd_dataN` = 0.
- Reset (any time, including mid-drain):
  - Queue flushed; `count` = 0, `empty` = 1, `full` = 0, `in_ready` = 1.
  - `RegWrite` = 0, `WriteReg` = 0, `WriteData` = 0; `hazard*` = 0 and `fwd_data*` = 0.
  - Pending writes are lost.
  - Outputs change immediately on `RESET` rise; the first push is possible at the first posedge after `RESET` falls.

## Timing
- Latency with an empty queue and no hold: accepted at edge N, popped at edge N+1 (`RegWrite`=1 for the cycle after N+1), committed at edge N+2.
- Throughput: one push and one pop per cycle sustained.
- `wr_hold` held for k cycles delays the pop by k edges. With `wr_hold` high at edge M, `RegWrite` is 0 in the cycle after M.
- `in_ready`, `count`, `empty`, `full` change only on posedge or `RESET`.
- `hazard*`/`fwd_data*` reflect state after the most recent edge: an entry pushed at edge N is visible from just after N. An entry written at edge M (`RegWrite`=1 before M) is no longer visible after M unless another candidate matches.

## Test plan
- Reset then single push reg 2 = 0x7: `RegWrite`=1, `WriteReg`=2, `WriteData`=0x7 exactly one cycle after acceptance; `hazard1`=1 with `ReadReg1`=2 until the commit edge, then 0.
- Push reg 0 = 0xFF: `in_ready`=1 and handshake completes, `count` stays 0, `RegWrite` never asserted; `ReadReg1`=0 gives `hazard1`=0.
- `wr_hold`=1, push regs 5,6,7,8 (0x10..0x13): `full`=1, `in_ready`=0, `count`=4; extra `in_valid` ignored. Release hold: four consecutive `RegWrite` pulses in order 5,6,7,8, then `empty`=1.
- Forwarding: `wr_hold`=1, push reg 9 = 0xA then reg 9 = 0xB; `ReadReg2`=9 → `hazard2`=1, `fwd_data2`=0xB; writes drain 0xA then 0xB.
- Continuous push/pop for 10 cycles, regs 1..10, data = reg×3: `count` ≤1, writes emitted in order with the correct data across pointer wrap.
- Assert `RESET` with 3 entries pending and `RegWrite`=1: `RegWrite`, `count`, `hazard*` go to 0 immediately; no further writes after release.

Source files
------------

// File: rtl/reg_writeback_queue.sv
// reg_writeback_queue
// Register-file write-back unit. ALU results (destination register and value)
// enter through a valid/ready handshake and wait in a small in-order FIFO.
// Entries then drive the register-file write port, at most one write per cycle.
// The unit also reports pending-write hazards and supplies the newest pending
// value for the two decode-stage read addresses.
//
// Ports:
//   CLK, RESET            clock; asynchronous active-high reset
//   in_valid/in_ready     result handshake; in_reg/in_data carry the result
//   wr_hold               register file busy, no pop this cycle
//   RegWrite/WriteReg/WriteData   registered write port to the register file
//   ReadReg1/ReadReg2     decode-stage read addresses
//   hazard1/hazard2       a write to ReadRegN is still pending
//   fwd_data1/fwd_data2   newest pending value for ReadRegN (0 if none)
//   count/empty/full      FIFO occupancy
module reg_writeback_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_reg,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     wr_hold,
  output logic                     RegWrite,
  output logic [ADDR_W-1:0]        WriteReg,
  output logic [DATA_W-1:0]        WriteData,
  input  logic [ADDR_W-1:0]        ReadReg1,
  input  logic [ADDR_W-1:0]        ReadReg2,
  output logic                     hazard1,
  output logic                     hazard2,
  output logic [DATA_W-1:0]        fwd_data1,
  output logic [DATA_W-1:0]        fwd_data2,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [CNT_W-1:0]  count_next;
  logic              regwrite_reg;
  logic [ADDR_W-1:0] writereg_reg;
  logic [DATA_W-1:0] writedata_reg;

  // Entry storage is read combinationally by the hazard logic, so it is
  // kept in flops rather than block RAM. Validity comes from the pointers
  // and count, so the contents need no reset.
  logic [ADDR_W-1:0] entry_addr_reg [DEPTH];
  logic [DATA_W-1:0] entry_data_reg [DEPTH];

  logic push_acc;
  logic push_en;
  logic pop_en;

  assign empty    = (count_reg == '0);
  assign full     = (count_reg == CNT_W'(DEPTH));
  assign in_ready = !full;
  assign count    = count_reg;

  assign push_acc = in_valid && in_ready;
  // A result for register 0 completes the handshake but is dropped.
  assign push_en  = push_acc && (in_reg != '0);
  assign pop_en   = !empty && !wr_hold;

  always_comb begin
    count_next = count_reg;
    case ({push_en, pop_en})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      regwrite_reg  <= 1'b0;
      writereg_reg  <= '0;
      writedata_reg <= '0;
    end else begin
      count_reg    <= count_next;
      regwrite_reg <= pop_en;
      if (push_en) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop_en) begin
        rd_ptr_reg    <= rd_ptr_reg + PTR_W'(1);
        writereg_reg  <= entry_addr_reg[rd_ptr_reg];
        writedata_reg <= entry_data_reg[rd_ptr_reg];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (push_en) begin
      entry_addr_reg[wr_ptr_reg] <= in_reg;
      entry_data_reg[wr_ptr_reg] <= in_data;
    end
  end

  assign RegWrite  = regwrite_reg;
  assign WriteReg  = writereg_reg;
  assign WriteData = writedata_reg;

  // Entries re-ordered by age: slot 0 is the head (oldest queued), slot
  // DEPTH-1 the newest possible position.
  logic              age_valid [DEPTH];
  logic [ADDR_W-1:0] age_addr  [DEPTH];
  logic [DATA_W-1:0] age_data  [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_age
      logic [PTR_W-1:0] idx;
      assign idx           = rd_ptr_reg + PTR_W'(gi);
      assign age_valid[gi] = (CNT_W'(gi) < count_reg);
      assign age_addr[gi]  = entry_addr_reg[idx];
      assign age_data[gi]  = entry_data_reg[idx];
    end
  endgenerate

  // Scan oldest to newest so the last match wins. The output register is
  // older than every queued entry, so it is considered first.
  always_comb begin
    hazard1   = 1'b0;
    hazard2   = 1'b0;
    fwd_data1 = '0;
    fwd_data2 = '0;
    if (regwrite_reg && (writereg_reg == ReadReg1) && (ReadReg1 != '0)) begin
      hazard1   = 1'b1;
      fwd_data1 = writedata_reg;
    end
    if (regwrite_reg && (writereg_reg == ReadReg2) && (ReadReg2 != '0)) begin
      hazard2   = 1'b1;
      fwd_data2 = writedata_reg;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (age_valid[i] && (age_addr[i] == ReadReg1) && (ReadReg1 != '0)) begin
        hazard1   = 1'b1;
        fwd_data1 = age_data[i];
      end
      if (age_valid[i] && (age_addr[i] == ReadReg2) && (ReadReg2 != '0)) begin
        hazard2   = 1'b1;
        fwd_data2 = age_data[i];
      end
    end
  end

endmodule

// File: tb/tb_reg_writeback_queue.sv
// tb_reg_writeback_queue
// Self-checking bench for reg_writeback_queue. A queue-based reference model
// tracks pending writes and the register-file write port; directed scenarios
// and a randomized run compare the DUT against it.
module tb_reg_writeback_queue;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_reg = '0;
  logic [31:0] in_data = '0;
  logic        wr_hold = 1'b0;
  logic        RegWrite;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic [4:0]  ReadReg1 = '0;
  logic [4:0]  ReadReg2 = '0;
  logic        hazard1, hazard2;
  logic [31:0] fwd_data1, fwd_data2;
  logic [2:0]  count;
  logic        empty, full;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference model: pending writes in acceptance order, plus the write port.
  logic [4:0]  mq_reg[$];
  logic [31:0] mq_data[$];
  logic        m_we = 1'b0;
  logic [4:0]  m_wr = '0;
  logic [31:0] m_wd = '0;

  reg_writeback_queue #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5)) dut (
    .CLK(CLK), .RESET(RESET),
    .in_valid(in_valid), .in_ready(in_ready), .in_reg(in_reg), .in_data(in_data),
    .wr_hold(wr_hold),
    .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
    .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
    .hazard1(hazard1), .hazard2(hazard2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
    .count(count), .empty(empty), .full(full)
  );

  always #5 CLK = ~CLK;

  function automatic void model_clear();
    mq_reg.delete();
    mq_data.delete();
    m_we = 1'b0;
    m_wr = '0;
    m_wd = '0;
  endfunction

  // Newest pending write to address a (the write port counts as oldest).
  function automatic void model_lookup(input logic [4:0] a, output logic hit,
                                       output logic [31:0] d);
    hit = 1'b0;
    d   = '0;
    if (a != 0) begin
      if (m_we && m_wr == a) begin
        hit = 1'b1;
        d   = m_wd;
      end
      for (int i = 0; i < mq_reg.size(); i++) begin
        if (mq_reg[i] == a) begin
          hit = 1'b1;
          d   = mq_data[i];
        end
      end
    end
  endfunction

  // One clock edge: model and DUT step together; returns 1 time unit after.
  task automatic advance();
    logic do_pop, do_push;
    logic [4:0]  r;
    logic [31:0] d;
    do_pop  = (mq_reg.size() > 0) && !wr_hold;
    do_push = in_valid && (mq_reg.size() < DEPTH) && (in_reg != 0);
    r = in_reg;
    d = in_data;
    @(posedge CLK);
    if (do_pop) begin
      m_we = 1'b1;
      m_wr = mq_reg.pop_front();
      m_wd = mq_data.pop_front();
    end else begin
      m_we = 1'b0;
    end
    if (do_push) begin
      mq_reg.push_back(r);
      mq_data.push_back(d);
    end
    #1;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    total_cnt++;
    if ({count, empty, full, in_ready, RegWrite} !== {3'd0, 1'b1, 1'b0, 1'b1, 1'b0})
      $display("FAIL reset_status count=%0d empty=%0b full=%0b in_ready=%0b RegWrite=%0b expected 0/1/0/1/0",
               count, empty, full, in_ready, RegWrite);
    else pass_cnt++;
    total_cnt++;
    if ({WriteReg, WriteData, hazard1, hazard2, fwd_data1, fwd_data2} !== '0)
      $display("FAIL reset_port WriteReg=%0d WriteData=%h hz=%0b%0b fwd=%h/%h expected all zero",
               WriteReg, WriteData, hazard1, hazard2, fwd_data1, fwd_data2);
    else pass_cnt++;
    model_clear();
    RESET = 1'b0;
  endtask

  task automatic test_single();
    ReadReg1 = 5'd2;
    in_reg = 5'd2; in_data = 32'h7; in_valid = 1'b1;
    advance();
    in_valid = 1'b0;
    total_cnt++;
    if ({hazard1, fwd_data1, RegWrite, count} !== {1'b1, 32'h7, 1'b0, 3'd1})
      $display("FAIL single_accept hz1=%0b fwd1=%h RegWrite=%0b count=%0d expected 1/7/0/1",
               hazard1, fwd_data1, RegWrite, count);
    else pass_cnt++;
    advance();
    total_cnt++;
    if ({RegWrite, WriteReg, WriteData, hazard1, count} !== {1'b1, 5'd2, 32'h7, 1'b1, 3'd0})
      $display("FAIL single_pop RegWrite=%0b WriteReg=%0d WriteData=%h hz1=%0b count=%0d expected 1/2/7/1/0",
               RegWrite, WriteReg, WriteData, hazard1, count);
    else pass_cnt++;
    advance();
    total_cnt++;
    if ({RegWrite, hazard1, fwd_data1} !== {1'b0, 1'b0, 32'h0})
      $display("FAIL single_commit RegWrite=%0b hz1=%0b fwd1=%h expected 0/0/0",
               RegWrite, hazard1, fwd_data1);
    else pass_cnt++;
  endtask

  task automatic test_reg0();
    in_reg = 5'd0; in_data = 32'hFF; in_valid = 1'b1;
    #1;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL reg0_ready got=%0b expected 1", in_ready);
    else pass_cnt++;
    advance();
    in_valid = 1'b0;
    ReadReg1 = 5'd0;
    #1;
    total_cnt++;
    if ({count, RegWrite, hazard1} !== {3'd0, 1'b0, 1'b0})
      $display("FAIL reg0_drop count=%0d RegWrite=%0b hz1=%0b expected 0/0/0", count, RegWrite, hazard1);
    else pass_cnt++;
    advance();
    total_cnt++;
    if (RegWrite !== 1'b0) $display("FAIL reg0_nowrite RegWrite=%0b expected 0", RegWrite);
    else pass_cnt++;
  endtask

  task automatic test_full();
    wr_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_reg = 5'(5 + i); in_data = 32'h10 + 32'(i); in_valid = 1'b1;
      advance();
    end
    total_cnt++;
    if ({full, in_ready, count} !== {1'b1, 1'b0, 3'd4})
      $display("FAIL full_flags full=%0b in_ready=%0b count=%0d expected 1/0/4", full, in_ready, count);
    else pass_cnt++;
    in_reg = 5'd20; in_data = 32'h99; in_valid = 1'b1;
    advance();
    total_cnt++;
    if ({count, RegWrite} !== {3'd4, 1'b0})
      $display("FAIL full_ignore count=%0d RegWrite=%0b expected 4/0", count, RegWrite);
    else pass_cnt++;
    in_valid = 1'b0;
    wr_hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      advance();
      total_cnt++;
      if ({RegWrite, WriteReg, WriteData} !== {1'b1, 5'(5 + i), 32'h10 + 32'(i)})
        $display("FAIL drain_%0d RegWrite=%0b WriteReg=%0d WriteData=%h expected 1/%0d/%h",
                 i, RegWrite, WriteReg, WriteData, 5 + i, 32'h10 + 32'(i));
      else pass_cnt++;
    end
    total_cnt++;
    if (empty !== 1'b1) $display("FAIL drain_empty got=%0b expected 1", empty);
    else pass_cnt++;
    advance();
    total_cnt++;
    if (RegWrite !== 1'b0) $display("FAIL drain_idle RegWrite=%0b expected 0", RegWrite);
    else pass_cnt++;
  endtask

  task automatic test_forward();
    wr_hold = 1'b1;
    in_reg = 5'd9; in_data = 32'hA; in_valid = 1'b1;
    advance();
    in_data = 32'hB;
    advance();
    in_valid = 1'b0;
    ReadReg2 = 5'd9;
    #1;
    total_cnt++;
    if ({hazard2, fwd_data2} !== {1'b1, 32'hB})
      $display("FAIL fwd_newest hz2=%0b fwd2=%h expected 1/b", hazard2, fwd_data2);
    else pass_cnt++;
    wr_hold = 1'b0;
    advance();
    total_cnt++;
    if ({RegWrite, WriteData, hazard2, fwd_data2} !== {1'b1, 32'hA, 1'b1, 32'hB})
      $display("FAIL fwd_first RegWrite=%0b WriteData=%h hz2=%0b fwd2=%h expected 1/a/1/b",
               RegWrite, WriteData, hazard2, fwd_data2);
    else pass_cnt++;
    advance();
    total_cnt++;
    if ({RegWrite, WriteData, hazard2, fwd_data2} !== {1'b1, 32'hB, 1'b1, 32'hB})
      $display("FAIL fwd_second RegWrite=%0b WriteData=%h hz2=%0b fwd2=%h expected 1/b/1/b",
               RegWrite, WriteData, hazard2, fwd_data2);
    else pass_cnt++;
    advance();
    total_cnt++;
    if ({RegWrite, hazard2} !== 2'b00)
      $display("FAIL fwd_done RegWrite=%0b hz2=%0b expected 0/0", RegWrite, hazard2);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 11; i++) begin
      if (i <= 10) begin
        in_reg = 5'(i); in_data = 32'(3 * i); in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      advance();
      total_cnt++;
      if (count > 3'd1) $display("FAIL stream_count_%0d got=%0d expected <=1", i, count);
      else pass_cnt++;
      if (i >= 2) begin
        total_cnt++;
        if ({RegWrite, WriteReg, WriteData} !== {1'b1, 5'(i - 1), 32'(3 * (i - 1))})
          $display("FAIL stream_write_%0d RegWrite=%0b WriteReg=%0d WriteData=%0d expected 1/%0d/%0d",
                   i, RegWrite, WriteReg, WriteData, i - 1, 3 * (i - 1));
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_random();
    logic h1, h2;
    logic [31:0] d1, d2;
    for (int c = 0; c < 400; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_reg   = 5'($urandom_range(0, 7));
      in_data  = $urandom;
      wr_hold  = ($urandom_range(0, 3) == 0);
      ReadReg1 = 5'($urandom_range(0, 7));
      ReadReg2 = 5'($urandom_range(0, 7));
      #1;
      model_lookup(ReadReg1, h1, d1);
      model_lookup(ReadReg2, h2, d2);
      total_cnt++;
      if ({count, empty, full, in_ready} !==
          {3'(mq_reg.size()), mq_reg.size() == 0, mq_reg.size() == DEPTH, mq_reg.size() < DEPTH})
        $display("FAIL rand_status_%0d count=%0d empty=%0b full=%0b ready=%0b expected count=%0d",
                 c, count, empty, full, in_ready, mq_reg.size());
      else pass_cnt++;
      total_cnt++;
      if ({RegWrite, WriteReg, WriteData} !== {m_we, m_wr, m_wd})
        $display("FAIL rand_port_%0d got=%0b/%0d/%h expected %0b/%0d/%h",
                 c, RegWrite, WriteReg, WriteData, m_we, m_wr, m_wd);
      else pass_cnt++;
      total_cnt++;
      if ({hazard1, fwd_data1, hazard2, fwd_data2} !== {h1, d1, h2, d2})
        $display("FAIL rand_fwd_%0d rr=%0d/%0d got=%0b/%h %0b/%h expected %0b/%h %0b/%h",
                 c, ReadReg1, ReadReg2, hazard1, fwd_data1, hazard2, fwd_data2, h1, d1, h2, d2);
      else pass_cnt++;
      advance();
    end
    in_valid = 1'b0;
    wr_hold  = 1'b0;
    for (int c = 0; c < 6; c++) advance();
  endtask

  task automatic test_reset_mid();
    wr_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_reg = 5'(11 + i); in_data = $urandom; in_valid = 1'b1;
      advance();
    end
    in_valid = 1'b0;
    wr_hold = 1'b0;
    ReadReg1 = 5'd12;
    advance();
    total_cnt++;
    if ({RegWrite, count, hazard1} !== {1'b1, 3'd3, 1'b1})
      $display("FAIL mid_before RegWrite=%0b count=%0d hz1=%0b expected 1/3/1", RegWrite, count, hazard1);
    else pass_cnt++;
    RESET = 1'b1;
    #1;
    total_cnt++;
    if ({RegWrite, count, empty, hazard1, fwd_data1, WriteReg, WriteData} !==
        {1'b0, 3'd0, 1'b1, 1'b0, 32'h0, 5'd0, 32'h0})
      $display("FAIL mid_reset RegWrite=%0b count=%0d empty=%0b hz1=%0b fwd1=%h WriteReg=%0d WriteData=%h expected 0/0/1/0/0/0/0",
               RegWrite, count, empty, hazard1, fwd_data1, WriteReg, WriteData);
    else pass_cnt++;
    model_clear();
    @(posedge CLK);
    #3;
    RESET = 1'b0;
    for (int i = 0; i < 4; i++) begin
      advance();
      total_cnt++;
      if ({RegWrite, count} !== {1'b0, 3'd0})
        $display("FAIL mid_after_%0d RegWrite=%0b count=%0d expected 0/0", i, RegWrite, count);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_reg0();
    test_full();
    test_forward();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
